// File: rtl/sync_up_range_cntr.sv
// Synchronous LOW..HIGH up counter with enable, range-checked load, terminal count
// and illegal-state recovery. Optional 8-bit wrap counter under SYNC_UP_CNTR_WRAP_CNT_EN.
module sync_up_range_cntr #(
  parameter int WIDTH = 3,
  parameter int LOW   = 2,
  parameter int HIGH  = 5
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qBar,
  output logic             tc,
  output logic             load_err
`ifdef SYNC_UP_CNTR_WRAP_CNT_EN
  ,
  output logic [7:0]       wrap_cnt
`endif
);

  generate
    if ((LOW < 0) || (LOW >= HIGH) || (HIGH > (2 ** WIDTH) - 1)) begin : g_param_err
      $error("sync_up_range_cntr: need 0 <= LOW < HIGH <= 2**WIDTH-1");
    end
  endgenerate

  localparam logic [WIDTH-1:0] LO = WIDTH'(LOW);
  localparam logic [WIDTH-1:0] HI = WIDTH'(HIGH);

  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] q_nxt;
  logic             in_range_q;
  logic             in_range_d;
  logic             load_err_nxt;

  // Next-state logic reads the q port net so an upset on q is seen directly.
  assign q          = q_r;
  assign qBar       = ~q;
  assign in_range_q = (q >= LO) && (q <= HI);
  assign in_range_d = (d >= LO) && (d <= HI);
  assign tc         = clear & en & (q == HI) & ~load;

  always_comb begin
    q_nxt        = q;
    load_err_nxt = 1'b0;
    if (!in_range_q) begin
      q_nxt = LO;
    end else if (load) begin
      if (in_range_d) begin
        q_nxt = d;
      end else begin
        q_nxt        = LO;
        load_err_nxt = 1'b1;
      end
    end else if (en) begin
      if (q == HI) q_nxt = LO;
      else         q_nxt = q + 1'b1;
    end
  end

  // One flop per bit; the async clear value of each bit comes from LOW.
  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      always_ff @(posedge clk or negedge clear) begin
        if (!clear) q_r[i] <= LO[i];
        else        q_r[i] <= q_nxt[i];
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) load_err <= 1'b0;
    else        load_err <= load_err_nxt;
  end

`ifdef SYNC_UP_CNTR_WRAP_CNT_EN
  logic wrap;

  assign wrap = in_range_q & ~load & en & (q == HI);

  always_ff @(posedge clk or negedge clear) begin
    if (!clear)    wrap_cnt <= 8'd0;
    else if (wrap) wrap_cnt <= wrap_cnt + 8'd1;
  end
`endif

endmodule
